// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: request encodings, FSM states and
// the access-size helper used by both the lane logic and the controller.
package lsu_pkg;

    typedef enum logic {LOAD = 1'b0, STORE = 1'b1} op_t;

    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_t;

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

    function automatic int lane_bytes(input size_t sz);
        return 1 << sz;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane datapath: load extract/extend, store merge and
// alignment check for one access of the given size at lane offset off_i.
module lsu_lane
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  size_t                       size_i,
    input  logic                        sext_i,
    input  logic [$clog2(DATA_W/8)-1:0] off_i,
    input  logic [DATA_W-1:0]           word_i,
    input  logic [DATA_W-1:0]           wdata_i,
    output logic [DATA_W-1:0]           ld_o,
    output logic [DATA_W-1:0]           mrg_o,
    output logic                        mis_o,
    output logic                        full_o
);
    localparam int NB = DATA_W / 8;

    int                nb;
    int                off;
    logic [DATA_W-1:0] rd_sh;
    logic [DATA_W-1:0] wr_sh;
    logic              sign;

    always_comb begin
        nb    = lane_bytes(size_i);
        off   = int'(off_i);
        rd_sh = word_i >> {off_i, 3'b000};
        wr_sh = wdata_i << {off_i, 3'b000};
        sign  = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (b == nb - 1) sign = rd_sh[8*b+7];
        end
        ld_o  = '0;
        mrg_o = '0;
        for (int b = 0; b < NB; b++) begin
            ld_o[8*b +: 8]  = (b < nb) ? rd_sh[8*b +: 8] : {8{sext_i & sign}};
            mrg_o[8*b +: 8] = (b >= off && b < off + nb) ? wr_sh[8*b +: 8] : word_i[8*b +: 8];
        end
        // An access wider than the memory word can never be aligned.
        mis_o  = (nb > NB) || ((off & (nb - 1)) != 0);
        full_o = (nb == NB);
    end

endmodule

// File: rtl/lsu_rmw.sv
// Sequenced load/store unit: aligned memory reads with MEM_LAT latency,
// read-modify-write for sub-word stores, misaligned requests rejected early.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_l,
    input  logic              start,
    input  logic              op,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int               OFF_W    = $clog2(DATA_W / 8);
    localparam int               CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    size_t             size_q, size_d;
    logic              sext_q, sext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mis_q, mis_d;

    size_t             lane_size;
    logic [OFF_W-1:0]  lane_off;
    logic [DATA_W-1:0] lane_word, lane_ld, lane_mrg;
    logic              lane_mis, lane_full;

    // In IDLE the lane judges the incoming request; afterwards the latched one.
    assign lane_size = (state_q == IDLE) ? size_t'(size) : size_q;
    assign lane_off  = (state_q == IDLE) ? addr[OFF_W-1:0] : addr_q[OFF_W-1:0];
    assign lane_word = (state_q == RD) ? mem_rdata : word_q;

    lsu_lane #(.DATA_W(DATA_W)) u_lane (
        .size_i  (lane_size),
        .sext_i  (sext_q),
        .off_i   (lane_off),
        .word_i  (lane_word),
        .wdata_i (wdata_q),
        .ld_o    (lane_ld),
        .mrg_o   (lane_mrg),
        .mis_o   (lane_mis),
        .full_o  (lane_full)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_t'(op);
                    size_d  = size_t'(size);
                    sext_d  = sign_ext;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = '0;
                    mis_d   = lane_mis;
                    if (lane_mis)                          state_d = DONE;
                    else if (op_t'(op) == STORE && lane_full) state_d = WR;
                    else                                   state_d = RD;
                end
            end
            RD: begin
                if (cnt_q == CNT_LAST) begin
                    word_d = mem_rdata;
                    if (op_q == LOAD) begin
                        rdata_d = lane_ld;
                        state_d = DONE;
                    end else begin
                        state_d = WR;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            op_q    <= LOAD;
            size_q  <= SZ_B;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign misalign  = done && mis_q;
    assign rdata     = rdata_q;
    assign mem_wr    = (state_q == WR);
    assign mem_wdata = (state_q == WR) ? lane_mrg : '0;
    assign mem_addr  = (state_q == RD || state_q == WR)
                     ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;

endmodule

// File: tb/tb_lsu_rmw.sv
// Scoreboard bench for lsu_rmw: three configurations (32b/lat1, 32b/lat3,
// 64b/lat1) driven with directed and random requests against a byte-array model.
module tb_lsu_rmw;

    typedef struct {
        int          t0;
        int          n;
        bit          mis;
        logic [63:0] rd;
        int          nrd;
        logic [31:0] wa;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [63:0] d;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string name, input int cfg, input logic [63:0] act,
                            input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL cfg%0d %s: got 0x%0h expected 0x%0h", cfg, name, act, exp);
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int DW    = (g == 2) ? 64 : 32;
        localparam int LAT   = (g == 1) ? 3 : 1;
        localparam int NB    = DW / 8;
        localparam int NW    = 16;
        localparam int NBYTE = NW * NB;

        logic          rst_n = 1'b0;
        logic          start = 1'b0;
        logic          op    = 1'b0;
        logic          sext  = 1'b0;
        logic [1:0]    size  = 2'd0;
        logic [31:0]   addr  = '0;
        logic [DW-1:0] wdata = '0;
        logic          busy, done, mis, mwr;
        logic [DW-1:0] rdata, mwdata, mrdata;
        logic [31:0]   maddr;

        logic [DW-1:0] mem [NW];
        logic [DW-1:0] dly [LAT];
        logic          load_mem = 1'b0;
        int            midx;
        byte unsigned  rb [NBYTE];
        logic [63:0]   last_rd = '0;
        exp_t          q[$];
        wr_t           wq[$];
        int            nrd_seen = 0;
        bit            fin_q = 1'b0;

        lsu_rmw #(.DATA_W(DW), .ADDR_W(32), .MEM_LAT(LAT)) dut (
            .clock     (clk),
            .reset_l   (rst_n),
            .start     (start),
            .op        (op),
            .size      (size),
            .sign_ext  (sext),
            .addr      (addr),
            .wdata     (wdata),
            .busy      (busy),
            .done      (done),
            .misalign  (mis),
            .rdata     (rdata),
            .mem_addr  (maddr),
            .mem_wr    (mwr),
            .mem_wdata (mwdata),
            .mem_rdata (mrdata)
        );

        function automatic logic [DW-1:0] rb_word(input int w);
            logic [DW-1:0] v;
            for (int b = 0; b < NB; b++) v[8*b +: 8] = rb[w*NB + b];
            return v;
        endfunction

        // Memory: writes land on the edge; read data appears LAT cycles after the address.
        assign midx = int'((maddr / 32'(NB)) % 32'(NW));
        always @(posedge clk) begin
            if (load_mem) begin
                for (int w = 0; w < NW; w++) mem[w] <= rb_word(w);
            end else if (mwr) begin
                mem[midx] <= mwdata;
            end
            dly[0] <= mem[midx];
            for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
        end
        if (LAT == 1) begin : g_comb
            assign mrdata = mem[midx];
        end else begin : g_pipe
            assign mrdata = dly[LAT-2];
        end

        always @(negedge clk) begin
            exp_t e;
            wr_t  w;
            if (!rst_n) begin
                nrd_seen = 0;
            end else begin
                if (mwr) begin
                    if (wq.size() == 0) check_eq("unexpected_wr", g, 64'(mwr), 64'd0);
                    else begin
                        w = wq.pop_front();
                        check_eq("wr_addr", g, 64'(maddr), 64'(w.a));
                        check_eq("wr_data", g, 64'(mwdata), w.d);
                    end
                end
                if (busy && !done && !mwr) begin
                    nrd_seen++;
                    if (q.size() > 0) check_eq("rd_addr", g, 64'(maddr), 64'(q[0].wa));
                end
                if (mis && !done) check_eq("misalign_without_done", g, 64'(mis), 64'd0);
                if (done) begin
                    if (q.size() == 0) check_eq("unexpected_done", g, 64'(done), 64'd0);
                    else begin
                        e = q.pop_front();
                        check_eq("misalign", g, 64'(mis), 64'(e.mis));
                        check_eq("rdata", g, 64'(rdata), e.rd);
                        check_eq("latency", g, 64'(cyc - e.t0), 64'(e.n));
                        check_eq("rd_cycles", g, 64'(nrd_seen), 64'(e.nrd));
                        check_eq("wr_pending", g, 64'(wq.size()), 64'd0);
                    end
                    nrd_seen = 0;
                end
            end
        end

        // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
        task automatic issue(input bit o, input logic [1:0] sz, input bit se,
                             input logic [31:0] a, input logic [63:0] wd);
            exp_t e;
            int   nb;
            logic [63:0] v;
            nb    = 1 << sz;
            e.t0  = cyc;
            e.mis = (nb > NB) || (a % nb != 0);
            e.wa  = a - a % NB;
            if (e.mis) begin
                e.n = 1; e.nrd = 0;
            end else if (!o) begin
                e.n = LAT + 1; e.nrd = LAT;
                v = '0;
                for (int i = 0; i < NB; i++)
                    v[8*i +: 8] = (i < nb) ? rb[a + i] : ((se && rb[a + nb - 1][7]) ? 8'hFF : 8'h00);
                last_rd = v;
            end else begin
                e.n   = (nb == NB) ? 2 : LAT + 2;
                e.nrd = (nb == NB) ? 0 : LAT;
                for (int i = 0; i < nb; i++) rb[a + i] = wd[8*i +: 8];
                wq.push_back('{a: e.wa, d: 64'(rb_word(int'(e.wa) / NB))});
            end
            e.rd = last_rd;
            q.push_back(e);
            start = 1'b1; op = o; size = sz; sext = se; addr = a; wdata = DW'(wd);
            @(negedge clk);
            for (int k = 0; k < 40 && !done; k++) begin
                start = 1'($urandom); op = 1'($urandom); size = 2'($urandom);
                addr = $urandom; wdata = DW'({$urandom, $urandom});
                @(negedge clk);
            end
            if (!done) check_eq("done_timeout", g, 64'(done), 64'd1);
            start = 1'b0;
            @(negedge clk);
        endtask

        task automatic issue_rand();
            logic [1:0]  sz;
            logic [31:0] a;
            int          nb;
            sz = 2'($urandom);
            nb = 1 << sz;
            a  = $urandom_range(0, NBYTE - 1);
            if ($urandom % 4 != 0 && nb <= NB) a = a - a % nb;
            issue(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom});
        endtask

        task automatic reset_mid_rd(input logic [31:0] a);
            start = 1'b1; op = 1'b1; size = 2'd1; sext = 1'b0; addr = a;
            wdata = DW'({$urandom, $urandom});
            @(negedge clk);
            start = 1'b0;
            check_eq("busy_before_reset", g, 64'(busy), 64'd1);
            rst_n = 1'b0;
            #1;
            check_eq("busy_in_reset", g, 64'(busy), 64'd0);
            check_eq("wr_in_reset", g, 64'(mwr), 64'd0);
            check_eq("rdata_in_reset", g, 64'(rdata), 64'd0);
            repeat (2) begin
                @(negedge clk);
                check_eq("wr_after_reset", g, 64'(mwr), 64'd0);
            end
            rst_n   = 1'b1;
            last_rd = '0;
            @(negedge clk);
        endtask

        initial begin
            for (int i = 0; i < NBYTE; i++) rb[i] = 8'($urandom);
            rb[16] = 8'hBB; rb[17] = 8'hAA; rb[18] = 8'h99; rb[19] = 8'h88;
            load_mem = 1'b1;
            #1;
            check_eq("rst_busy", g, 64'(busy), 64'd0);
            check_eq("rst_done", g, 64'(done), 64'd0);
            check_eq("rst_misalign", g, 64'(mis), 64'd0);
            check_eq("rst_mem_wr", g, 64'(mwr), 64'd0);
            check_eq("rst_rdata", g, 64'(rdata), 64'd0);
            check_eq("rst_mem_addr", g, 64'(maddr), 64'd0);
            check_eq("rst_mem_wdata", g, 64'(mwdata), 64'd0);
            @(negedge clk);
            load_mem = 1'b0;
            rst_n    = 1'b1;

            issue(1'b0, 2'd0, 1'b1, 32'h12, 64'h0);
            issue(1'b0, 2'd1, 1'b0, 32'h12, 64'h0);
            issue(1'b0, 2'd2, 1'b0, 32'h10, 64'h0);
            issue(1'b1, 2'd0, 1'b0, 32'h11, 64'h5A);
            issue(1'b0, 2'd2, 1'b0, 32'h10, 64'h0);
            issue(1'b0, 2'd2, 1'b0, 32'h13, 64'h0);
            issue(1'b0, 2'd3, 1'b1, 32'h10, 64'h0);
            issue(1'b1, 2'd3, 1'b0, 32'h08, {$urandom, $urandom});
            issue(1'b1, 2'd2, 1'b0, 32'h04, {$urandom, $urandom});
            issue(1'b0, 2'd2, 1'b1, 32'h04, 64'h0);
            issue(1'b0, 2'd3, 1'b0, 32'h08, 64'h0);

            for (int n = 0; n < 60; n++) begin
                issue_rand();
                if ($urandom % 3 == 0) @(negedge clk);
            end

            reset_mid_rd(32'h22);
            issue(1'b0, 2'd1, 1'b0, 32'h22, 64'h0);
            for (int n = 0; n < 10; n++) issue_rand();
            repeat (2) @(negedge clk);
            check_eq("scoreboard_drained", g, 64'(q.size() + wq.size()), 64'd0);
            fin_q = 1'b1;
        end
    end

    initial begin
        fork
            wait (cfg[0].fin_q && cfg[1].fin_q && cfg[2].fin_q);
            #500000;
        join_any
        disable fork;
        if (!(cfg[0].fin_q && cfg[1].fin_q && cfg[2].fin_q))
            check_eq("global_timeout", 0,
                     64'({cfg[2].fin_q, cfg[1].fin_q, cfg[0].fin_q}), 64'd7);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_rmw.md
# lsu_rmw

Parametrised load/store unit sitting between the multicycle datapath and the data memory. It replaces the fixed byte/half extenders and sub-word store adders with one sequenced block. Given a request (load or store; byte, half, word or dword; signed or unsigned), it performs aligned memory accesses with a configurable read latency. Sub-word stores are done as read-modify-write, and misaligned requests are flagged without touching memory.

## Interface
Parameters:
- DATA_W, 32, memory word width; legal values 32 or 64
- ADDR_W, 32, byte-address width
- MEM_LAT, 1, cycles from mem_addr presented to mem_rdata valid; must be ≥ 1

Ports:
- clock  in  1  single clock, rising edge
- reset_l  in  1  asynchronous, active-low reset
- start  in  1  request strobe, sampled only in IDLE
- op  in  1  0 = load, 1 = store
- size  in  2  00 byte, 01 half, 10 word, 11 dword
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  store data, right-justified
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- misalign  out  1  valid with done; request rejected
- rdata  out  DATA_W  load result, held until the next load completes
- mem_addr  out  ADDR_W  aligned word address (low log2(DATA_W/8) bits zero)
- mem_wr  out  1  write enable, one cycle per store
- mem_wdata  out  DATA_W  merged write word
- mem_rdata  in  DATA_W  memory read data

## Operation
- Byte lanes are little-endian. OFF = addr[log2(DATA_W/8)-1:0] selects the lane.
- States: IDLE, RD, WR, DONE.
- IDLE + start: latch op, size, sign_ext, addr and wdata.
  - Misaligned → DONE with misalign=1. Misaligned means: half with OFF[0]≠0; word with OFF[1:0]≠0; dword with OFF≠0; dword when DATA_W=32.
  - Full-width store (word at DATA_W=32, dword at DATA_W=64) → WR.
  - Otherwise → RD.
- RD: mem_wr=0; a counter runs MEM_LAT cycles. On the last RD edge, mem_rdata is captured into the word register.
  - Load → DONE.
  - Sub-word store → WR.
- WR: mem_wr=1 for exactly one cycle. mem_wdata = captured word with the sized lane(s) at OFF replaced by the low bits of wdata (full-width store: wdata). → DONE.
- DONE: done=1 for one cycle.
  - Load: rdata = lane extracted at OFF, extended per sign_ext.
  - Store or misalign: rdata unchanged. → IDLE.
- start outside IDLE is ignored, with no queuing.
- mem_addr = latched addr with the low offset bits cleared, driven in RD and WR; 0 in IDLE.

## Timing
- Reset values (asynchronous): state IDLE; busy, done, misalign, mem_wr = 0; rdata, mem_addr, mem_wdata, counter, latches = 0.
- Latency, counted from start sampled at edge k (done high in the cycle after edge k+n):
  - Misaligned: n=1.
  - Full-width store: mem_wr in cycle k+1, done at n=2.
  - Load: n = MEM_LAT+1.
  - Sub-word store: mem_wr in cycle k+MEM_LAT+1, done at n = MEM_LAT+2.
- A new start is accepted in the cycle after done, so back-to-back requests lose no cycle beyond DONE.
- Reset asserted mid-operation: mem_wr drops immediately, no partial write is issued, state returns to IDLE.
- misalign is low whenever done is low.

## Structure
- lsu_pkg:
  - op_t (LOAD/STORE), size_t (SZ_B/SZ_H/SZ_W/SZ_D), state_t enums
  - function giving lane byte count from size_t
- Sub-module lsu_lane, purely combinational, parametrised on DATA_W:
  - extract + extend for loads
  - lane merge for stores
  - misalign detection
- lsu_rmw holds the FSM, latency counter ($clog2(MEM_LAT+1) bits) and registers.

## Test plan
Default DATA_W=32, MEM_LAT=1, memory model with mem[0x10]=0x8899AABB.
- Load byte, sign_ext=1, addr 0x12 → rdata 0xFFFFFF99, done 2 cycles after start, mem_wr never high.
- Load half, sign_ext=0, addr 0x12 → rdata 0x00008899. Load word, addr 0x10 → 0x8899AABB.
- Store byte, wdata 0x0000005A, addr 0x11 → one read of 0x10, then exactly one mem_wr cycle with mem_wdata 0x88995ABB; done at start+3.
- Load word at addr 0x13, and load dword at DATA_W=32 → done+misalign at start+1; no RD or WR; rdata unchanged.
- MEM_LAT=3 variant:
  - Word store → mem_wr at start+1, done at start+2.
  - Word load → done at start+4.
  - DATA_W=64 dword store at 0x08 → no read.
- reset_l pulsed low during RD of a half store → mem_wr stays 0, busy 0 immediately; the next load returns the original data.
